instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Instruction store that sits directly upstream of the 8-bit processor core. It takes the core's `pc` and returns the 8-bit `instruction` by asynchronous read. It also holds the core in reset until a program has been streamed in over a valid/ready byte interface. The block owns the program image: it loads bytes into a DEPTH x 8 array, tracks program length, and gates the core's reset.

Parameters:
DEPTH, 256, number of instruction bytes stored; legal range 2..256, and the address width is 8.
NOP_INSTR, 8'h00, byte returned while not running or when `pc` is at or beyond the loaded length.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
load_start  input  1  one-cycle pulse that begins a new program load.
load_valid  input  1  `load_data` holds a valid byte.
load_data  input  8  program byte.
load_last  input  1  qualifies the final byte of the program; sampled with `load_valid`.
load_ready  output  1  block accepts a byte this cycle.
pc  input  8  program counter from the core.
instruction  output  8  instruction byte to the core.
cpu_reset  output  1  active-high reset to the core.
program_length  output  9  number of bytes in the current image (0..DEPTH).
overflow  output  1  sticky flag: the load hit DEPTH without `load_last`.

Behaviour:
- Reset (`reset`=0, async):
  - state=IDLE, write pointer=0, `program_length`=0, `overflow`=0.
  - `cpu_reset`=1, `load_ready`=0, `instruction`=NOP_INSTR.
  - Array contents are not reset.
- IDLE:
  - `cpu_reset`=1, `instruction`=NOP_INSTR.
  - `load_start`=1 -> LOAD on the next edge; write pointer=0, `program_length`=0, `overflow`=0.
- LOAD:
  - `load_ready`=1, `cpu_reset`=1, `instruction`=NOP_INSTR.
  - Handshake: a byte transfers on a posedge with `load_valid` && `load_ready`.
  - On a transfer: mem[wp] <= `load_data`, wp <= wp+1, `program_length` <= wp+1.
  - Transfer with `load_last`=1 -> RUN next cycle.
  - Transfer that writes address DEPTH-1 without `load_last` -> RUN, `overflow`=1, and `load_ready` drops the following cycle.
  - `load_valid` without `load_ready` is ignored; no stall requirement is placed on the source.
  - `load_start` inside LOAD restarts: wp=0, `program_length`=0, and any byte presented in that same cycle is discarded.
- RUN:
  - `cpu_reset`=0 from the first cycle in RUN (registered output, one cycle after the last transfer).
  - `load_ready`=0.
  - `instruction` = mem[`pc`] combinationally if `pc` < `program_length`, else NOP_INSTR. There is zero latency because the core changes `pc` on the falling edge and consumes `instruction` in the same cycle.
  - `load_start` -> LOAD: `cpu_reset`=1 from the next posedge, and `instruction` falls to NOP_INSTR in the same cycle that `cpu_reset` rises.
- A zero-length program is not possible: the `load_last` byte is always stored.
- Reset asserted mid-load abandons the load. `program_length`=0 and the partial image is treated as absent.
- `load_start` coincident with a data transfer in IDLE: the start takes effect and the data is not accepted (`load_ready`=0 in IDLE).
- Write and read never alias: reads only occur in RUN, writes only in LOAD.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined: adds output `checksum` [7:0], the mod-256 sum of all bytes accepted since the last `load_start`. It resets to 0 on `reset` and on `load_start`, and updates on each transfer.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset released, no load -> `cpu_reset`=1, `instruction`=8'h00, `program_length`=0, `load_ready`=0 for 20 cycles.
- `load_start`, then bytes 8'h41, 8'h52, 8'hC7 (last on 8'hC7) with `load_valid` held -> `program_length`=3. `cpu_reset` falls one cycle after the 8'hC7 transfer. `pc`=0/1/2 gives 8'h41/8'h52/8'hC7, and `pc`=3 gives 8'h00.
- Same load with `load_valid` toggling every other cycle -> only the qualified bytes are stored, with an identical final image and length.
- 256 bytes (value = index) without `load_last` -> `overflow`=1, `program_length`=256, state RUN, `pc`=8'hFF gives 8'hFF.
- `load_start` in RUN after a 3-byte program, then reload 1 byte 8'h10 -> `cpu_reset`=1 during the reload. `pc`=1 returns 8'h00 (length 1) even though mem[1] still holds 8'h52.
- Reset asserted after 2 of 3 bytes -> immediately `cpu_reset`=1 and `program_length`=0. With LOADER_CHECKSUM_EN, the 3-byte load above gives `checksum`=8'h5A.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: program store for the 8-bit core; streams an image in over
// valid/ready, holds the core in reset until loaded, then serves mem[pc].
// Optional feature macro: LOADER_CHECKSUM_EN adds the checksum output.
module instr_mem_loader #(
   parameter int         DEPTH     = 256,
   parameter logic [7:0] NOP_INSTR = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_start,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   input  logic       load_last,
   output logic       load_ready,
   input  logic [7:0] pc,
   output logic [7:0] instruction,
   output logic       cpu_reset,
   output logic [8:0] program_length,
   output logic       overflow
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0] checksum
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] LAST_ADDR = 9'(DEPTH - 1);

   state_t     state, state_nxt;
   logic [8:0] wp, wp_nxt;
   logic       ovf_nxt;
   logic       xfer;
   logic [7:0] mem [DEPTH];

   // Next state, write pointer and overflow; a start always wins over data
   always_comb begin
      state_nxt = state;
      wp_nxt    = wp;
      ovf_nxt   = overflow;
      xfer      = 1'b0;
      if (load_start) begin
         state_nxt = LOAD;
         wp_nxt    = '0;
         ovf_nxt   = 1'b0;
      end else if (state == LOAD && load_valid) begin
         xfer   = 1'b1;
         wp_nxt = wp + 9'd1;
         if (load_last) begin
            state_nxt = RUN;
         end else if (wp == LAST_ADDR) begin
            state_nxt = RUN;
            ovf_nxt   = 1'b1;
         end
      end
   end

   // State register; cpu_reset is registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         wp        <= '0;
         overflow  <= 1'b0;
         cpu_reset <= 1'b1;
      end else begin
         state     <= state_nxt;
         wp        <= wp_nxt;
         overflow  <= ovf_nxt;
         cpu_reset <= (state_nxt != RUN);
      end
   end

   // Program array, written only during LOAD and never reset
   always_ff @(posedge clk) begin
      if (xfer) mem[wp[AW-1:0]] <= load_data;
   end

   // The write pointer doubles as the image length
   assign program_length = wp;
   assign load_ready     = (state == LOAD);
   assign instruction    = (state == RUN && {1'b0, pc} < wp) ? mem[pc[AW-1:0]] : NOP_INSTR;

`ifdef LOADER_CHECKSUM_EN
   // Mod-256 sum of bytes accepted since the last start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) checksum <= 8'h00;
      else if (load_start) checksum <= 8'h00;
      else if (xfer) checksum <= checksum + load_data;
   end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized bench with a behavioural image model for instr_mem_loader.
module tb_instr_mem_loader;

   localparam int         DEPTH = 256;
   localparam logic [7:0] NOP   = 8'h00;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load_start = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       load_last = 1'b0;
   logic [7:0] pc = 8'h00;
   logic       load_ready;
   logic [7:0] instruction;
   logic       cpu_reset;
   logic [8:0] program_length;
   logic       overflow;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   bit         m_loading, m_running, m_ovf;
   int         m_len;
   logic [7:0] m_cs;
   logic [7:0] m_img [DEPTH];
   logic [7:0] prog [3];

   instr_mem_loader #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk),
      .reset(reset),
      .load_start(load_start),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_last(load_last),
      .load_ready(load_ready),
      .pc(pc),
      .instruction(instruction),
      .cpu_reset(cpu_reset),
      .program_length(program_length),
      .overflow(overflow)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Image model: what the loader holds, how long it is, and whether the core runs
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_loading <= 1'b0;
         m_running <= 1'b0;
         m_len     <= 0;
         m_ovf     <= 1'b0;
         m_cs      <= 8'h00;
      end else if (load_start) begin
         m_loading <= 1'b1;
         m_running <= 1'b0;
         m_len     <= 0;
         m_ovf     <= 1'b0;
         m_cs      <= 8'h00;
      end else if (m_loading && load_valid) begin
         m_img[m_len] <= load_data;
         m_len        <= m_len + 1;
         m_cs         <= m_cs + load_data;
         if (load_last || m_len + 1 == DEPTH) begin
            m_loading <= 1'b0;
            m_running <= 1'b1;
            m_ovf     <= !load_last;
         end
      end
   end

   // Every falling edge: outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cpu_reset", {31'd0, cpu_reset}, {31'd0, !m_running});
         check("load_ready", {31'd0, load_ready}, {31'd0, m_loading});
         check("program_length", {23'd0, program_length}, m_len);
         check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         check("instruction", {24'd0, instruction},
               {24'd0, (m_running && int'(pc) < m_len) ? m_img[pc] : NOP});
`ifdef LOADER_CHECKSUM_EN
         check("checksum", {24'd0, checksum}, {24'd0, m_cs});
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic chk_pc(input logic [7:0] p, input logic [7:0] exp);
      pc = p;
      #1;
      check("pc_read", {24'd0, instruction}, {24'd0, exp});
      tick();
   endtask

   task automatic load3(input bit toggle);
      start();
      for (int i = 0; i < 3; i++) begin
         if (toggle && i > 0) begin
            load_valid = 1'b0;
            load_data  = 8'($urandom);
            load_last  = 1'($urandom);
            tick();
         end
         send(prog[i], i == 2);
      end
   endtask

   initial begin
      prog[0] = 8'h41;
      prog[1] = 8'h52;
      prog[2] = 8'hC7;
      #2 reset = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      repeat (20) tick();
      check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("idle_instr", {24'd0, instruction}, 32'h00);
      check("idle_len", {23'd0, program_length}, 32'd0);
      check("idle_ready", {31'd0, load_ready}, 32'd0);

      load3(1'b0);
      check("l3_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      check("l3_len", {23'd0, program_length}, 32'd3);
`ifdef LOADER_CHECKSUM_EN
      check("l3_checksum", {24'd0, checksum}, 32'h5A);
`endif
      chk_pc(8'd0, 8'h41);
      chk_pc(8'd1, 8'h52);
      chk_pc(8'd2, 8'hC7);
      chk_pc(8'd3, 8'h00);

      load3(1'b1);
      check("tog_len", {23'd0, program_length}, 32'd3);
      chk_pc(8'd0, 8'h41);
      chk_pc(8'd1, 8'h52);
      chk_pc(8'd2, 8'hC7);
      chk_pc(8'd3, 8'h00);

      start();
      for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_len", {23'd0, program_length}, 32'd256);
      check("ovf_ready", {31'd0, load_ready}, 32'd0);
      check("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      send(8'h99, 1'b1);
      check("ovf_len_hold", {23'd0, program_length}, 32'd256);
      chk_pc(8'hFF, 8'hFF);

      load3(1'b0);
      pc = 8'd0;
      start();
      check("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("reload_instr", {24'd0, instruction}, 32'h00);
      send(8'h10, 1'b1);
      check("reload_len", {23'd0, program_length}, 32'd1);
      chk_pc(8'd1, 8'h00);
      chk_pc(8'd0, 8'h10);

      start();
      send(8'h41, 1'b0);
      send(8'h52, 1'b0);
      reset = 1'b0;
      #1;
      check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst_len", {23'd0, program_length}, 32'd0);
      check("rst_ready", {31'd0, load_ready}, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hEE;
      load_last  = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("start_data_len", {23'd0, program_length}, 32'd0);
      check("start_data_ready", {31'd0, load_ready}, 32'd1);
      send(8'h33, 1'b0);
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h77;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      check("restart_len", {23'd0, program_length}, 32'd0);
      send(8'h55, 1'b1);
      check("restart_len2", {23'd0, program_length}, 32'd1);
      chk_pc(8'd0, 8'h55);

      repeat (30) begin
         load_start = 1'b1;
         load_valid = 1'($urandom);
         load_data  = 8'($urandom);
         tick();
         load_start = 1'b0;
         for (int c = 0; c < 200; c++) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = 8'($urandom);
            load_last  = ($urandom_range(0, 15) == 0);
            load_start = ($urandom_range(0, 99) == 0);
            pc         = 8'($urandom);
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            tick();
            reset      = 1'b1;
            load_start = 1'b0;
            if (m_running) break;
         end
         load_last = 1'b0;
         repeat (12) begin
            pc         = 8'($urandom_range(0, (m_len > 255) ? 255 : m_len));
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            tick();
         end
         load_valid = 1'b0;
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
